// File: rtl/npu_stream_loader.sv
// Streams host beats into the image, conv-weight and dense-weight RAMs in fixed order.
// Optional running checksum output enabled by defining NPU_LOADER_CSUM_EN.
module npu_stream_loader #(
  parameter int DATA_W      = 32,
  parameter int LANES       = 4,
  parameter int IMG_WORDS   = 225,
  parameter int CONV_BYTES  = 18816,
  parameter int DENSE_WORDS = 4203,
  parameter int IMG_AW      = 10,
  parameter int CONV_AW     = 15,
  parameter int DENSE_AW    = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic                wr_valid,
  input  logic [DATA_W-1:0]   writedata,
  output logic                wr_ready,
  output logic                busy,
  output logic                done,
  output logic [1:0]          segment,
`ifdef NPU_LOADER_CSUM_EN
  output logic [31:0]         csum,
`endif
  output logic [LANES-1:0]    img_we,
  output logic [IMG_AW-1:0]   img_addr,
  output logic [DATA_W-1:0]   img_data,
  output logic                conv_we,
  output logic [CONV_AW-1:0]  conv_addr,
  output logic [7:0]          conv_data,
  output logic [LANES-1:0]    dense_we,
  output logic [DENSE_AW-1:0] dense_addr,
  output logic [DATA_W-1:0]   dense_data
);

  localparam int CNT_W = (IMG_AW > CONV_AW) ? ((IMG_AW > DENSE_AW) ? IMG_AW : DENSE_AW)
                                            : ((CONV_AW > DENSE_AW) ? CONV_AW : DENSE_AW);
  localparam logic [CNT_W-1:0] IMG_LAST   = CNT_W'(IMG_WORDS - 1);
  localparam logic [CNT_W-1:0] CONV_LAST  = CNT_W'(CONV_BYTES - 1);
  localparam logic [CNT_W-1:0] DENSE_LAST = CNT_W'(DENSE_WORDS - 1);

  if (DATA_W != 8 * LANES) begin : g_chk_width
    $error("npu_stream_loader: DATA_W must equal 8*LANES");
  end
  if (IMG_WORDS < 1 || IMG_WORDS > (1 << IMG_AW)) begin : g_chk_img
    $error("npu_stream_loader: IMG_WORDS out of range for IMG_AW");
  end
  if (CONV_BYTES < 1 || CONV_BYTES > (1 << CONV_AW)) begin : g_chk_conv
    $error("npu_stream_loader: CONV_BYTES out of range for CONV_AW");
  end
  if (DENSE_WORDS < 1 || DENSE_WORDS > (1 << DENSE_AW)) begin : g_chk_dense
    $error("npu_stream_loader: DENSE_WORDS out of range for DENSE_AW");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_IMG   = 2'd1,
    S_CONV  = 2'd2,
    S_DENSE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                img_we_q, img_we_d;
  logic [IMG_AW-1:0]   img_addr_q, img_addr_d;
  logic [DATA_W-1:0]   img_data_q, img_data_d;
  logic                conv_we_q, conv_we_d;
  logic [CONV_AW-1:0]  conv_addr_q, conv_addr_d;
  logic [7:0]          conv_data_q, conv_data_d;
  logic                dense_we_q, dense_we_d;
  logic [DENSE_AW-1:0] dense_addr_q, dense_addr_d;
  logic [DATA_W-1:0]   dense_data_q, dense_data_d;
  logic                done_q, done_d;
  logic                accept;

  assign busy     = (state_q != S_IDLE);
  assign wr_ready = busy && !abort;
  assign accept   = wr_valid && wr_ready;
  assign segment  = state_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    img_we_d     = 1'b0;
    conv_we_d    = 1'b0;
    dense_we_d   = 1'b0;
    done_d       = 1'b0;
    img_addr_d   = img_addr_q;
    img_data_d   = img_data_q;
    conv_addr_d  = conv_addr_q;
    conv_data_d  = conv_data_q;
    dense_addr_d = dense_addr_q;
    dense_data_d = dense_data_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_IMG;
          cnt_d   = '0;
        end
      end
      S_IMG: begin
        if (accept) begin
          img_we_d   = 1'b1;
          img_addr_d = cnt_q[IMG_AW-1:0];
          img_data_d = writedata;
          if (cnt_q == IMG_LAST) begin
            cnt_d   = '0;
            state_d = S_CONV;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_CONV: begin
        if (accept) begin
          conv_we_d   = 1'b1;
          conv_addr_d = cnt_q[CONV_AW-1:0];
          conv_data_d = writedata[7:0];
          if (cnt_q == CONV_LAST) begin
            cnt_d   = '0;
            state_d = S_DENSE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_DENSE: begin
        if (accept) begin
          dense_we_d   = 1'b1;
          dense_addr_d = cnt_q[DENSE_AW-1:0];
          dense_data_d = writedata;
          if (cnt_q == DENSE_LAST) begin
            cnt_d   = '0;
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Abort only matters mid-load; in IDLE a coincident start still takes effect.
    if (busy && abort) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  // Write-port register stage: one cycle from acceptance to RAM strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      img_we_q     <= 1'b0;
      img_addr_q   <= '0;
      img_data_q   <= '0;
      conv_we_q    <= 1'b0;
      conv_addr_q  <= '0;
      conv_data_q  <= '0;
      dense_we_q   <= 1'b0;
      dense_addr_q <= '0;
      dense_data_q <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      img_we_q     <= img_we_d;
      img_addr_q   <= img_addr_d;
      img_data_q   <= img_data_d;
      conv_we_q    <= conv_we_d;
      conv_addr_q  <= conv_addr_d;
      conv_data_q  <= conv_data_d;
      dense_we_q   <= dense_we_d;
      dense_addr_q <= dense_addr_d;
      dense_data_q <= dense_data_d;
      done_q       <= done_d;
    end
  end

  assign img_we     = {LANES{img_we_q}};
  assign img_addr   = img_addr_q;
  assign img_data   = img_data_q;
  assign conv_we    = conv_we_q;
  assign conv_addr  = conv_addr_q;
  assign conv_data  = conv_data_q;
  assign dense_we   = {LANES{dense_we_q}};
  assign dense_addr = dense_addr_q;
  assign dense_data = dense_data_q;
  assign done       = done_q;

`ifdef NPU_LOADER_CSUM_EN
  logic [31:0] csum_q, csum_d;

  function automatic logic [31:0] csum_add(input logic [31:0] acc, input logic [DATA_W-1:0] w);
    return acc + 32'(w);
  endfunction

  always_comb begin
    csum_d = csum_q;
    if (!busy && start) begin
      csum_d = '0;
    end else if (accept) begin
      csum_d = csum_add(csum_q, writedata);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign csum = csum_q;
`endif

endmodule

// File: tb/tb_npu_stream_loader.sv
// Scoreboard bench for npu_stream_loader with small segments (3 image, 4 conv, 2 dense beats).
module tb_npu_stream_loader;

  logic        clk = 1'b0;
  logic        reset, start, abort, wr_valid;
  logic [31:0] writedata;
  logic        wr_ready, busy, done;
  logic [1:0]  segment;
  logic [3:0]  img_we, dense_we;
  logic [3:0]  img_addr, conv_addr, dense_addr;
  logic [31:0] img_data, dense_data;
  logic        conv_we;
  logic [7:0]  conv_data;
`ifdef NPU_LOADER_CSUM_EN
  logic [31:0] csum;
`endif

  npu_stream_loader #(
    .DATA_W(32), .LANES(4), .IMG_WORDS(3), .CONV_BYTES(4), .DENSE_WORDS(2),
    .IMG_AW(4), .CONV_AW(4), .DENSE_AW(4)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .wr_valid(wr_valid), .writedata(writedata), .wr_ready(wr_ready),
    .busy(busy), .done(done), .segment(segment),
`ifdef NPU_LOADER_CSUM_EN
    .csum(csum),
`endif
    .img_we(img_we), .img_addr(img_addr), .img_data(img_data),
    .conv_we(conv_we), .conv_addr(conv_addr), .conv_data(conv_data),
    .dense_we(dense_we), .dense_addr(dense_addr), .dense_data(dense_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          grp;
    logic [31:0] addr;
    logic [31:0] data;
    bit          done;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected write for beat k (0-based) of a load: 0..2 image, 3..6 conv, 7..8 dense.
  function automatic exp_t beat_exp(input int k, input logic [31:0] w);
    exp_t e;
    e.done = 1'b0;
    if (k < 3) begin
      e.grp = 1; e.addr = k; e.data = w;
    end else if (k < 7) begin
      e.grp = 2; e.addr = k - 3; e.data = {24'h0, w[7:0]};
    end else begin
      e.grp = 3; e.addr = k - 7; e.data = w; e.done = (k == 8);
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(input int k, input logic [31:0] w);
    wr_valid  = 1'b1;
    writedata = w;
    sb.push_back(beat_exp(k, w));
    tick();
  endtask

  task automatic start_load();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_segment", 32'(segment), 32'd1);
`ifdef NPU_LOADER_CSUM_EN
    chk("start_csum_clear", csum, 32'd0);
`endif
  endtask

  task automatic run_load(input bit gaps, input int start_at);
    for (int k = 0; k < 9; k++) begin
      if (k == start_at) start = 1'b1;
      drive_beat(k, 32'(k + 1));
      start = 1'b0;
      if (k == 8) begin
        chk("done_busy_low", 32'(busy), 32'd0);
        chk("done_segment_idle", 32'(segment), 32'd0);
`ifdef NPU_LOADER_CSUM_EN
        chk("csum_at_done", csum, 32'd45);
`endif
      end
      if (gaps) begin
        wr_valid  = 1'b0;
        writedata = 32'hDEAD_BEEF;
        tick();
      end
    end
    wr_valid = 1'b0;
  endtask

  // Monitor: every strobe must match the head of the scoreboard.
  initial begin
    exp_t e;
    int   nwe;
    int   grp;
    logic [31:0] a, d;
    forever begin
      @(negedge clk);
      nwe = int'(|img_we) + int'(conv_we) + int'(|dense_we);
      if (nwe > 1) begin
        chk("strobe_overlap", 32'(nwe), 32'd1);
      end else if (nwe == 1) begin
        if (|img_we) begin
          grp = 1; a = 32'(img_addr); d = img_data;
          chk("img_we_lanes", 32'(img_we), 32'hF);
        end else if (conv_we) begin
          grp = 2; a = 32'(conv_addr); d = 32'(conv_data);
        end else begin
          grp = 3; a = 32'(dense_addr); d = dense_data;
          chk("dense_we_lanes", 32'(dense_we), 32'hF);
        end
        if (sb.size() == 0) begin
          chk("unexpected_strobe_grp", 32'(grp), 32'd0);
        end else begin
          e = sb.pop_front();
          chk("strobe_grp", 32'(grp), 32'(e.grp));
          chk("strobe_addr", a, e.addr);
          chk("strobe_data", d, e.data);
          chk("strobe_done", 32'(done), 32'(e.done));
        end
      end else if (done) begin
        chk("done_without_strobe", 32'(done), 32'd0);
      end
    end
  end

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; wr_valid = 1'b0; writedata = '0;
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd0);
    chk("rst_segment", 32'(segment), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    reset = 1'b0;
    tick();

    // Back-to-back load, then a new load started in the done cycle with gapped valid.
    start_load();
    run_load(1'b0, -1);
    start_load();
    run_load(1'b1, -1);
    repeat (2) tick();

    // wr_valid in IDLE is ignored.
    wr_valid = 1'b1; writedata = 32'h77;
    for (int i = 0; i < 3; i++) begin
      #1 chk("idle_wr_ready", 32'(wr_ready), 32'd0);
      tick();
    end
    wr_valid = 1'b0;

    // Abort after the 5th beat: beat 5 still strobes (conv addr 1), no done.
    start_load();
    for (int k = 0; k < 5; k++) drive_beat(k, 32'(k + 1));
    abort = 1'b1; wr_valid = 1'b1; writedata = 32'd6;
    #1 chk("abort_wr_ready", 32'(wr_ready), 32'd0);
    tick();
    abort = 1'b0; wr_valid = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_segment", 32'(segment), 32'd0);
    repeat (3) tick();

    // Abort in IDLE does nothing; start+abort together in IDLE starts a load.
    abort = 1'b1; tick(); abort = 1'b0;
    chk("idle_abort_busy", 32'(busy), 32'd0);
    start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
    chk("start_abort_busy", 32'(busy), 32'd1);
    chk("start_abort_seg", 32'(segment), 32'd1);

    // Restarted load begins at image addr 0; reset lands during the conv segment.
    for (int k = 0; k < 4; k++) drive_beat(k, 32'h10 + 32'(k));
    reset = 1'b1; wr_valid = 1'b1; writedata = 32'h55;
    tick();
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_segment", 32'(segment), 32'd0);
    chk("mid_rst_conv_we", 32'(conv_we), 32'd0);
    chk("mid_rst_conv_addr", 32'(conv_addr), 32'd0);
    chk("mid_rst_conv_data", 32'(conv_data), 32'd0);
    chk("mid_rst_img_addr", 32'(img_addr), 32'd0);
    chk("mid_rst_img_data", img_data, 32'd0);
    chk("mid_rst_dense_data", dense_data, 32'd0);
    chk("mid_rst_wr_ready", 32'(wr_ready), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_wr_ready", 32'(wr_ready), 32'd0);
    end
    wr_valid = 1'b0;

    // Start pulsed mid-load is ignored; the load completes normally.
    start_load();
    run_load(1'b0, 2);
    repeat (3) tick();

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
